tick_scheduler: RTL

Shared time-base controller for the slow-enable domain: one free-running prescaler produces a base tick, and four independently configured channels derive their own one-cycle enable pulses and square waves from it. Consumers (debouncers, display/"magic" animation, test blinkers) use these enables in place of private divided clocks. Configuration changes go through a valid/ready handshake and take effect only on a base-tick boundary, so every channel stays phase-aligned to the shared time base.

---
 rtl/tick_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/tick_scheduler.sv
// Shared slow-enable time base: one prescaler, four channels of tick and square outputs.
// Channel reconfiguration is handshaked and lands on a base-tick boundary.
module tick_scheduler #(
    parameter int unsigned BASE_DIV = 2000000,
    parameter int unsigned PRE_W    = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [1:0] cfg_ch,
    input  logic [7:0] cfg_period,
    input  logic       cfg_en,
    output logic       cfg_done,
    output logic       base_tick,
    output logic [3:0] tick_out,
    output logic [3:0] sq_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_DONE
    } state_t;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BASE_DIV - 1);

    logic [PRE_W-1:0] pre;
    state_t           state;
    logic [1:0]       lat_ch;
    logic [7:0]       lat_period;
    logic             lat_en;
    logic             commit;

    logic [3:0]       en;
    logic [7:0]       period  [4];
    logic [7:0]       cnt     [4];
    logic [7:0]       pe_last [4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre       <= '0;
            base_tick <= 1'b0;
        end else if (pre == PRE_LAST) begin
            pre       <= '0;
            base_tick <= 1'b1;
        end else begin
            pre       <= pre + PRE_W'(1);
            base_tick <= 1'b0;
        end
    end

    // A tick already high at acceptance is ignored: commit needs PEND first.
    assign commit = (state == S_PEND) && base_tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cfg_ready  <= 1'b1;
            cfg_done   <= 1'b0;
            lat_ch     <= '0;
            lat_period <= '0;
            lat_en     <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (cfg_valid) begin
                        lat_ch     <= cfg_ch;
                        lat_period <= cfg_period;
                        lat_en     <= cfg_en;
                        state      <= S_PEND;
                        cfg_ready  <= 1'b0;
                    end else begin
                        state     <= S_IDLE;
                        cfg_ready <= 1'b1;
                    end
                end
                S_PEND: begin
                    if (base_tick) begin
                        state     <= S_DONE;
                        cfg_done  <= 1'b1;
                        cfg_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pe_last[i] = (period[i] == 8'd0) ? 8'd0 : period[i] - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en       <= '0;
            tick_out <= '0;
            sq_out   <= '0;
            for (int i = 0; i < 4; i++) begin
                period[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                tick_out[i] <= 1'b0;
                if (commit && lat_ch == 2'(i)) begin
                    en[i]     <= lat_en;
                    period[i] <= lat_period;
                    cnt[i]    <= '0;
                    sq_out[i] <= 1'b0;
                end else if (base_tick && en[i]) begin
                    if (cnt[i] == pe_last[i]) begin
                        cnt[i]      <= '0;
                        tick_out[i] <= 1'b1;
                        sq_out[i]   <= ~sq_out[i];
                    end else begin
                        cnt[i] <= cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

endmodule
